// File: rtl/dram_ring_scheduler.sv
// rtl/dram_ring_scheduler.sv - MIG app/UI port sequencer treating the whole SDRAM as a ring buffer
module dram_ring_scheduler #(
   parameter int ADDR_WIDTH  = 24,
   parameter int DATA_WIDTH  = 128,
   parameter int MAX_BURST   = 128,
   parameter int MIN_BURST   = 32,
   parameter int MAX_PENDING = 31
) (
   input  logic                  uiclk,
   input  logic                  reset,
   input  logic                  wr_valid,
   input  logic                  wr_level_ok,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_rden,
   input  logic                  rd_space_ok,
   input  logic                  app_rdy,
   input  logic                  app_wdf_rdy,
   input  logic                  app_rd_data_valid,
   output logic                  app_en,
   output logic [2:0]            app_cmd,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [DATA_WIDTH-1:0] app_wdf_data,
   output logic                  app_wdf_wren,
   output logic [ADDR_WIDTH:0]   mem_free,
   output logic [5:0]            rd_pending,
   output logic                  underflow_err,
   output logic [1:0]            state
);

   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [ADDR_WIDTH:0]   RING       = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   RING_M1    = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0]   FREE_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   MIN_LVL    = (ADDR_WIDTH+1)'(MIN_BURST);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
   localparam logic [BW-1:0]         BURST_ONE  = BW'(1);
   localparam logic [BW-1:0]         BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [5:0]            PEND_ONE   = 6'd1;
   localparam logic [5:0]            PEND_MAX   = 6'(MAX_PENDING);
   localparam logic [5:0]            PEND_LAST  = 6'(MAX_PENDING - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WR   = 2'b01,
      RD   = 2'b10
   } state_t;

   state_t                cur_state;
   logic                  last_grant_rd;
   logic [BW-1:0]         burst_cnt;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   used;
   logic                  wr_ok, rd_ok, wr_slot, rd_slot, burst_done, wr_exit, rd_exit;

   assign used       = RING - mem_free;
   assign wr_ok      = wr_level_ok & app_wdf_rdy & (mem_free >= MIN_LVL);
   assign rd_ok      = rd_space_ok & (rd_pending == 6'd0) & (used >= MIN_LVL);
   assign wr_slot    = (cur_state == WR) & app_rdy & app_wdf_rdy & wr_valid & (mem_free != '0);
   assign rd_slot    = (cur_state == RD) & app_rdy & (mem_free != RING) & (rd_pending < PEND_MAX);
   assign burst_done = (burst_cnt == BURST_LAST);
   assign wr_exit    = ~wr_valid | ~app_wdf_rdy | (mem_free <= FREE_ONE) | (wr_slot & burst_done);
   assign rd_exit    = ~rd_space_ok | (mem_free >= RING_M1) | (rd_pending >= PEND_LAST)
                     | (rd_slot & burst_done);

   // The FIFO pop must not happen while the slot it feeds is being discarded by reset.
   assign wr_rden = wr_slot & ~reset;
   assign state   = cur_state;

   always_ff @(posedge uiclk) begin
      if (reset) begin
         cur_state     <= IDLE;
         last_grant_rd <= 1'b1;
         burst_cnt     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         mem_free      <= RING;
         rd_pending    <= '0;
         underflow_err <= 1'b0;
         app_en        <= 1'b0;
         app_cmd       <= 3'b000;
         app_addr      <= '0;
         app_wdf_data  <= '0;
         app_wdf_wren  <= 1'b0;
      end else begin
         case (cur_state)
            IDLE: begin
               if (wr_ok && (!rd_ok || last_grant_rd)) begin
                  cur_state     <= WR;
                  last_grant_rd <= 1'b0;
                  burst_cnt     <= '0;
               end else if (rd_ok) begin
                  cur_state     <= RD;
                  last_grant_rd <= 1'b1;
                  burst_cnt     <= '0;
               end
            end
            WR:      if (wr_exit) cur_state <= IDLE;
            RD:      if (rd_exit) cur_state <= IDLE;
            default: cur_state <= IDLE;
         endcase

         // Command registers only advance when the MIG has taken the previous one.
         if (app_rdy) begin
            if (wr_slot) begin
               app_en       <= 1'b1;
               app_cmd      <= 3'b000;
               app_addr     <= wr_ptr;
               app_wdf_data <= wr_data;
            end else if (rd_slot) begin
               app_en   <= 1'b1;
               app_cmd  <= 3'b001;
               app_addr <= rd_ptr;
            end else begin
               app_en <= 1'b0;
            end
         end

         if (wr_slot)          app_wdf_wren <= 1'b1;
         else if (app_wdf_rdy) app_wdf_wren <= 1'b0;

         if (wr_slot) begin
            wr_ptr    <= wr_ptr + PTR_ONE;
            mem_free  <= mem_free - FREE_ONE;
            burst_cnt <= burst_cnt + BURST_ONE;
         end else if (rd_slot) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            mem_free  <= mem_free + FREE_ONE;
            burst_cnt <= burst_cnt + BURST_ONE;
         end

         case ({rd_slot, app_rd_data_valid})
            2'b10:   rd_pending <= rd_pending + PEND_ONE;
            2'b01: begin
               if (rd_pending != 6'd0) rd_pending    <= rd_pending - PEND_ONE;
               else                    underflow_err <= 1'b1;
            end
            default: rd_pending <= rd_pending;
         endcase
      end
   end

endmodule
